// File: rtl/turn_ind_pkg.sv
// Shared types and elaboration-time helpers for the turn indicator LEDs.
package turn_ind_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TURN     = 3'd1,
    WIN_FL   = 3'd2,
    WIN_HOLD = 3'd3,
    DRAW     = 3'd4
  } state_t;

  // Clock cycles in one half of a blink period at frequency hz.
  function automatic int half_period(input int clk_hz, input int hz);
    return clk_hz / (2 * hz);
  endfunction

  // Index width for n players, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Parameter legality: player count, positive rates, and a fast half-period
  // that divides the slow half-period evenly so both phases stay aligned.
  function automatic bit params_ok(input int n, input int clk_hz, input int slow_hz,
                                   input int fast_div, input int win_flashes);
    int half;
    if (n < 2 || n > 8) return 1'b0;
    if (slow_hz < 1 || fast_div < 1 || win_flashes < 1) return 1'b0;
    half = half_period(clk_hz, slow_hz);
    if (half < fast_div) return 1'b0;
    if ((half % fast_div) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running blink prescaler producing slow and fast phase bits.
// Outputs are the phase values the flops take at the coming edge, so the LED
// register downstream can follow them with a single cycle of latency.
module blink_prescaler #(
  parameter int HALF_SLOW = 20,
  parameter int FAST_DIV  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic slow_ph_d,
  output logic fast_ph_d,
  output logic period_end
);

  localparam int FAST_HALF = HALF_SLOW / FAST_DIV;
  localparam int CW = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;
  localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  logic [CW-1:0] cnt, cnt_d;
  logic [FW-1:0] fcnt, fcnt_d;
  logic          slow_ph, fast_ph;
  logic          slow_tick, fast_tick;

  // Next counter/phase values; restart forces both phases on from count zero.
  always_comb begin
    slow_tick  = (cnt == CW'(HALF_SLOW - 1));
    fast_tick  = (fcnt == FW'(FAST_HALF - 1));
    cnt_d      = slow_tick ? '0 : cnt + CW'(1);
    fcnt_d     = fast_tick ? '0 : fcnt + FW'(1);
    slow_ph_d  = slow_ph ^ slow_tick;
    fast_ph_d  = fast_ph ^ fast_tick;
    period_end = slow_tick & ~slow_ph;
    if (restart) begin
      cnt_d      = '0;
      fcnt_d     = '0;
      slow_ph_d  = 1'b1;
      fast_ph_d  = 1'b1;
      period_end = 1'b0;
    end
  end

  // Prescaler and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      fcnt    <= '0;
      slow_ph <= 1'b0;
      fast_ph <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      fcnt    <= fcnt_d;
      slow_ph <= slow_ph_d;
      fast_ph <= fast_ph_d;
    end
  end

endmodule

// File: rtl/turn_indicator.sv
// Per-player turn LEDs: blink for the active player, flash then hold the
// winner at game end, or blink all LEDs together on a draw.
//
//   state    | meaning
//   IDLE     | no game, LEDs dark
//   TURN     | active player's LED blinks (fast while warn)
//   WIN_FL   | all LEDs flash WIN_FLASHES full periods
//   WIN_HOLD | winner's LED solid on
//   DRAW     | all LEDs blink in unison
module turn_indicator
  import turn_ind_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SLOW_HZ     = 1,
  parameter int FAST_DIV    = 4,
  parameter int WIN_FLASHES = 3,
  localparam int PW = idx_width(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_active,
  input  logic [PW-1:0]        current_player,
  input  logic                 warn,
  input  logic                 game_over,
  input  logic                 winner_valid,
  input  logic [PW-1:0]        winner,
  output logic [N_PLAYERS-1:0] led
);

  localparam int HALF_SLOW = half_period(CLK_HZ, SLOW_HZ);
  localparam int FW = (WIN_FLASHES > 1) ? $clog2(WIN_FLASHES) : 1;

  if (!params_ok(N_PLAYERS, CLK_HZ, SLOW_HZ, FAST_DIV, WIN_FLASHES)) begin : g_bad_params
    $error("turn_indicator: illegal parameter combination");
  end

  state_t                state, state_d;
  logic                  ga_q;
  logic [PW-1:0]         player_q, winner_q;
  logic [FW-1:0]         flash_cnt;
  logic                  restart, ga_rise, entering;
  logic                  slow_ph_d, fast_ph_d, period_end;
  logic                  ph_sel;
  logic [N_PLAYERS-1:0]  led_d;

  blink_prescaler #(
    .HALF_SLOW (HALF_SLOW),
    .FAST_DIV  (FAST_DIV)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .slow_ph_d  (slow_ph_d),
    .fast_ph_d  (fast_ph_d),
    .period_end (period_end)
  );

  // Next-state decision and phase restart request.
  always_comb begin
    state_d = state;
    ga_rise = game_active & ~ga_q;
    case (state)
      IDLE, TURN: begin
        if (game_over)
          state_d = winner_valid ? WIN_FL : DRAW;
        else if (state == IDLE && game_active)
          state_d = TURN;
        else if (state == TURN && !game_active)
          state_d = IDLE;
      end
      WIN_FL: begin
        if (ga_rise)
          state_d = TURN;
        else if (period_end && flash_cnt == FW'(WIN_FLASHES - 1))
          state_d = WIN_HOLD;
      end
      WIN_HOLD, DRAW: begin
        if (ga_rise) state_d = TURN;
      end
      default: state_d = IDLE;
    endcase
    entering = (state_d != state);
    restart  = (entering && (state_d == TURN || state_d == WIN_FL || state_d == DRAW)) ||
               (state == TURN && state_d == TURN && current_player != player_q);
  end

  // LED pattern for the coming cycle; out-of-range indices match no LED.
  always_comb begin
    led_d  = '0;
    ph_sel = warn ? fast_ph_d : slow_ph_d;
    case (state_d)
      TURN: begin
        for (int i = 0; i < N_PLAYERS; i++)
          led_d[i] = (current_player == PW'(i)) & ph_sel;
      end
      WIN_FL, DRAW: led_d = {N_PLAYERS{slow_ph_d}};
      WIN_HOLD: begin
        for (int i = 0; i < N_PLAYERS; i++)
          led_d[i] = (winner_q == PW'(i));
      end
      default: led_d = '0;
    endcase
  end

  // State, input history, winner latch, flash counter and LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ga_q      <= 1'b0;
      player_q  <= '0;
      winner_q  <= '0;
      flash_cnt <= '0;
      led       <= '0;
    end else begin
      state    <= state_d;
      ga_q     <= game_active;
      player_q <= current_player;
      led      <= led_d;
      if (entering && state_d == WIN_FL) begin
        winner_q  <= winner;
        flash_cnt <= '0;
      end else if (state == WIN_FL && period_end) begin
        flash_cnt <= flash_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_turn_indicator.sv
// Directed bench for turn_indicator with a 20-cycle slow half-period,
// 5-cycle fast half-period, three players and two win flashes.
module tb_turn_indicator;

  logic       clk;
  logic       rst_n;
  logic       game_active;
  logic [1:0] current_player;
  logic       warn;
  logic       game_over;
  logic       winner_valid;
  logic [1:0] winner;
  logic [2:0] led;

  int tests = 0;
  int fails = 0;
  int t     = 0;

  turn_indicator #(
    .N_PLAYERS   (3),
    .CLK_HZ      (40),
    .SLOW_HZ     (1),
    .FAST_DIV    (4),
    .WIN_FLASHES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_active    (game_active),
    .current_player (current_player),
    .warn           (warn),
    .game_over      (game_over),
    .winner_valid   (winner_valid),
    .winner         (winner),
    .led            (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    tests++;
    assert (led === exp)
    else begin
      fails++;
      $error("FAIL %s: led=%b expected=%b (t=%0d)", tag, led, exp, t);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    game_active = 1'b0;
    current_player = 2'd0;
    warn = 1'b0;
    game_over = 1'b0;
    winner_valid = 1'b0;
    winner = 2'd0;

    #1 rst_n = 1'b0;
    #2 chk("reset_async", 3'b000);
    #17 rst_n = 1'b1;
    chk("reset_state", 3'b000);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_dark", 3'b000);
    end

    // Turn of player 1: slow cadence, then fast under warn, then slow again.
    game_active = 1'b1;
    current_player = 2'd1;
    tick();
    chk("turn_start", 3'b010);
    for (int d = 1; d <= 45; d++) begin
      tick();
      chk("turn_slow", ((d / 20) % 2 == 0) ? 3'b010 : 3'b000);
    end
    warn = 1'b1;
    for (int d = 46; d <= 64; d++) begin
      tick();
      chk("turn_fast", ((d / 5) % 2 == 0) ? 3'b010 : 3'b000);
    end
    warn = 1'b0;
    for (int d = 65; d <= 105; d++) begin
      tick();
      chk("turn_slow2", ((d / 20) % 2 == 0) ? 3'b010 : 3'b000);
    end

    // Switch to player 2 while led[1] is dark.
    current_player = 2'd2;
    tick();
    chk("switch_first", 3'b100);
    for (int d = 1; d <= 24; d++) begin
      tick();
      chk("switch_hold", (d < 20) ? 3'b100 : 3'b000);
    end

    // Player 0 wins: two full flash periods then solid.
    game_over = 1'b1;
    winner_valid = 1'b1;
    winner = 2'd0;
    tick();
    game_over = 1'b0;
    chk("win_fl_start", 3'b111);
    for (int d = 1; d <= 85; d++) begin
      tick();
      chk("win_flash", (d >= 80) ? 3'b001 : (((d / 20) % 2 == 0) ? 3'b111 : 3'b000));
    end
    game_over = 1'b1;
    winner_valid = 1'b0;
    winner = 2'd1;
    tick();
    game_over = 1'b0;
    chk("end_gameover_ignored", 3'b001);
    game_active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_inactive", 3'b001);
    end
    game_active = 1'b1;
    tick();
    chk("new_game_turn", 3'b100);

    // Draw: all LEDs blink together.
    game_over = 1'b1;
    winner_valid = 1'b0;
    tick();
    game_over = 1'b0;
    chk("draw_start", 3'b111);
    for (int d = 1; d <= 45; d++) begin
      tick();
      chk("draw_blink", ((d / 20) % 2 == 0) ? 3'b111 : 3'b000);
    end
    game_active = 1'b0;
    tick();
    chk("draw_hold_inactive", 3'b111);
    game_active = 1'b1;
    tick();
    chk("draw_new_game", 3'b100);

    // Out-of-range player index keeps every LED dark.
    current_player = 2'd3;
    for (int d = 0; d < 25; d++) begin
      tick();
      chk("player_oob", 3'b000);
    end
    current_player = 2'd0;
    tick();
    chk("player0", 3'b001);

    // Reset in the middle of a win flash.
    game_over = 1'b1;
    winner_valid = 1'b1;
    winner = 2'd2;
    tick();
    game_over = 1'b0;
    chk("win2_start", 3'b111);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("win2_flash", 3'b111);
    end
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_win", 3'b000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_held", 3'b000);
    end
    rst_n = 1'b1;
    tick();
    chk("after_reset_turn", 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
